// File: rtl/gauss5_stream_filter_if.sv
// Pixel stream interface for the 5x5 Gaussian filter: input stream, output stream and frame marker.
interface gauss5_stream_filter_if #(
    parameter int unsigned PW = 8
);
    logic [1:0]    mode;
    logic [PW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [PW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          frame_done;

    modport master (
        output mode, din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, frame_done
    );

    modport slave (
        input  mode, din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, frame_done
    );
endinterface

// File: rtl/gauss5_stream_filter.sv
// Streaming 5x5 separable Gaussian filter: 4 line buffers, 5x5 window, 3-stage pipeline.
module gauss5_stream_filter #(
    parameter int unsigned PW    = 8,
    parameter int unsigned IMG_W = 600,
    parameter int unsigned IMG_H = 450
) (
    input logic                   clk,
    input logic                   rst,
    gauss5_stream_filter_if.slave bus
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned AW = PW + 8;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [1:0]    r_mode;
    logic [PW-1:0] r_lb [4][IMG_W];
    logic [PW-1:0] r_win [5][5];
    logic          r_s1_valid, r_s1_last;
    logic [1:0]    r_s1_mode;
    logic [AW-1:0] r_s2_row [5];
    logic          r_s2_valid, r_s2_last;
    logic [1:0]    r_s2_mode;
    logic [PW-1:0] r_dout;
    logic          r_dout_valid, r_frame_done;

    logic          w_advance, w_accept, w_win_ok, w_last;
    logic [PW-1:0] w_col_px [5];
    logic [AW-1:0] w_row_sum [5];
    logic [AW-1:0] w_col_sum, w_round;
    logic [3:0]    w_shift;
    logic [PW-1:0] w_dout;

    // 1-D tap weights; mode 3 is a centre-only tap so bypass shares the datapath.
    function automatic logic [AW-1:0] weight(input logic [1:0] m, input int k);
        logic [AW-1:0] w;
        w = '0;
        unique case (m)
            2'd0: w = (k == 2) ? AW'(6) : ((k == 1 || k == 3) ? AW'(4) : AW'(1));
            2'd1: w = (k == 0 || k == 4) ? AW'(1) : AW'(2);
            2'd2: w = (k == 2) ? AW'(2) : ((k == 1 || k == 3) ? AW'(1) : AW'(0));
            2'd3: w = (k == 2) ? AW'(1) : AW'(0);
        endcase
        return w;
    endfunction

    function automatic logic [3:0] shift_of(input logic [1:0] m);
        logic [3:0] s;
        s = 4'd0;
        unique case (m)
            2'd0: s = 4'd8;
            2'd1: s = 4'd6;
            2'd2: s = 4'd4;
            2'd3: s = 4'd0;
        endcase
        return s;
    endfunction

    assign w_advance = bus.dout_ready | ~r_dout_valid;
    assign w_accept  = bus.din_valid & w_advance;
    assign w_win_ok  = (r_row >= RW'(4)) && (r_col >= CW'(4));
    assign w_last    = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));

    // New window column, top (row-4) to bottom (current row).
    assign w_col_px[0] = r_lb[3][r_col];
    assign w_col_px[1] = r_lb[2][r_col];
    assign w_col_px[2] = r_lb[1][r_col];
    assign w_col_px[3] = r_lb[0][r_col];
    assign w_col_px[4] = bus.din;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_row_sum[i] = '0;
            for (int j = 0; j < 5; j++) begin
                w_row_sum[i] = w_row_sum[i] + weight(r_s1_mode, j) * AW'(r_win[i][j]);
            end
        end
        w_col_sum = '0;
        for (int i = 0; i < 5; i++) begin
            w_col_sum = w_col_sum + weight(r_s2_mode, i) * r_s2_row[i];
        end
        w_shift = shift_of(r_s2_mode);
        w_round = (w_shift == 4'd0) ? '0 : (AW'(1) << (w_shift - 4'd1));
        w_dout  = PW'((w_col_sum + w_round) >> w_shift);
    end

    // Storage without reset: row counting guarantees stale contents are never used.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= bus.din;
            for (int k = 1; k < 4; k++) begin
                r_lb[k][r_col] <= r_lb[k-1][r_col];
            end
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
                r_win[i][4] <= w_col_px[i];
            end
        end
        if (w_advance) begin
            r_s1_last <= w_last;
            r_s1_mode <= r_mode;
            r_s2_last <= r_s1_last;
            r_s2_mode <= r_s1_mode;
            r_s2_row  <= w_row_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_mode       <= '0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_dout       <= '0;
        end else begin
            if (w_accept) begin
                if (r_col == '0 && r_row == '0) begin
                    r_mode <= bus.mode;
                end
                if (r_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            if (w_advance) begin
                r_s1_valid   <= w_accept & w_win_ok;
                r_s2_valid   <= r_s1_valid;
                r_dout_valid <= r_s2_valid;
                r_frame_done <= r_s2_valid & r_s2_last;
                if (r_s2_valid) begin
                    r_dout <= w_dout;
                end
            end
        end
    end

    assign bus.din_ready  = w_advance;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_gauss5_stream_filter.sv
// Directed and randomised bench for gauss5_stream_filter with a window-model scoreboard.
module tb_gauss5_stream_filter;
    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gauss5_stream_filter_if #(.PW(8)) bus ();

    gauss5_stream_filter #(.PW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         acc44   = 0;
    int         img [H][W];
    int         t_row   = 0;
    int         t_col   = 0;
    logic [1:0] f_mode  = 2'd0;
    bit         accepted = 1'b0;
    bit         rnd_ready = 1'b0;
    int         sb_val [$];
    bit         sb_fd [$];
    int         got [$];
    int         got_cyc [$];
    int         fd_cnt = 0;
    int         fd_idx = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] prev_dout = 8'd0;
    logic       prev_fd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int kw(input logic [1:0] m, input int k);
        int t [3][5] = '{'{1, 4, 6, 4, 1}, '{1, 2, 2, 2, 1}, '{0, 1, 2, 1, 0}};
        return t[int'(m)][k];
    endfunction

    // Direct 2-D convolution over the frame image held by the bench.
    function automatic int ref_px(input int r, input int c);
        int s;
        int sh;
        if (f_mode == 2'd3) return img[r-2][c-2];
        s = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                s += kw(f_mode, i) * kw(f_mode, j) * img[r-4+i][c-4+j];
        sh = (f_mode == 2'd0) ? 8 : ((f_mode == 2'd1) ? 6 : 4);
        return (s + (1 << (sh - 1))) >> sh;
    endfunction

    task automatic model_accept(input logic [7:0] pix, input logic [1:0] m);
        if (t_row == 0 && t_col == 0) f_mode = m;
        img[t_row][t_col] = int'(pix);
        if (t_row >= 4 && t_col >= 4) begin
            sb_val.push_back(ref_px(t_row, t_col));
            sb_fd.push_back(t_row == H - 1 && t_col == W - 1);
            if (t_row == 4 && t_col == 4) acc44 = cyc;
        end
        if (t_col == W - 1) begin
            t_col = 0;
            t_row = (t_row == H - 1) ? 0 : t_row + 1;
        end else begin
            t_col++;
        end
        accepted = 1'b1;
    endtask

    task automatic mon();
        int e;
        bit f;
        if (stall_prev) begin
            chk("stall_valid_hold", 32'(bus.dout_valid), 32'd1);
            chk("stall_dout_hold", 32'(bus.dout), 32'(prev_dout));
            chk("stall_fd_hold", 32'(bus.frame_done), 32'(prev_fd));
        end
        if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b0)
            chk("stall_din_ready", 32'(bus.din_ready), 32'd0);
        if (bus.frame_done === 1'b1)
            chk("fd_with_valid", 32'(bus.dout_valid), 32'd1);
        if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
            got.push_back(int'(bus.dout));
            got_cyc.push_back(cyc);
            if (bus.frame_done === 1'b1) begin
                fd_cnt++;
                fd_idx = got.size();
            end
            if (sb_val.size() == 0) begin
                chk("sb_unexpected_output", 32'(bus.dout_valid), 32'd0);
            end else begin
                e = sb_val.pop_front();
                f = sb_fd.pop_front();
                chk("sb_dout", 32'(bus.dout), e);
                chk("sb_frame_done", 32'(bus.frame_done), 32'(f));
            end
        end
        stall_prev = (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b0);
        prev_dout  = bus.dout;
        prev_fd    = bus.frame_done;
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        accepted = 1'b0;
        if (rst === 1'b1 && bus.din_valid === 1'b1 && bus.din_ready === 1'b1)
            model_accept(bus.din, bus.mode);
        @(posedge clk);
        #1;
        cyc++;
        bus.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_px(input logic [7:0] p, input logic [1:0] m);
        bus.din       = p;
        bus.mode      = m;
        bus.din_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) begin
            chk("accept_timeout", 32'(accepted), 32'd1);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "input stream stalled");
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int cval, input logic [1:0] m0,
                              input logic [1:0] m1);
        logic [7:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       p = 8'(cval);
                    1:       p = (r == 2 && c == 2) ? 8'd255 : 8'd0;
                    2:       p = 8'(r * 8 + c);
                    default: p = 8'($urandom_range(0, 255));
                endcase
                send_px(p, (r >= 3) ? m1 : m0);
            end
        end
    endtask

    task automatic drain();
        bus.din_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (sb_val.size() == 0) break;
            cycle();
        end
        chk("drain_empty", sb_val.size(), 0);
        repeat (5) cycle();
    endtask

    task automatic clear_frame_stats();
        got.delete();
        got_cyc.delete();
        fd_cnt = 0;
        fd_idx = 0;
    endtask

    initial begin
        int ramp_exp [8] = '{18, 19, 20, 21, 26, 27, 28, 29};
        int imp_exp [3]  = '{36, 16, 64};

        bus.din        = 8'd0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        bus.mode       = 2'd0;
        rst            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_dout", 32'(bus.dout), 32'd0);
        chk("reset_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
        chk("reset_din_ready", 32'(bus.din_ready), 32'd1);

        // Constant image, every kernel
        for (int m = 0; m < 4; m++) begin
            clear_frame_stats();
            send_frame(0, 100, 2'(m), 2'(m));
            drain();
            chk("const_count", got.size(), 8);
            chk("const_fd_count", fd_cnt, 1);
            chk("const_fd_at_8th", fd_idx, 8);
            for (int i = 0; i < got.size(); i++) chk("const_value", got[i], 100);
            if (m == 0 && got_cyc.size() > 0) chk("latency", got_cyc[0] - acc44, 3);
        end

        // Impulse at (2,2)
        for (int m = 0; m < 3; m++) begin
            clear_frame_stats();
            send_frame(1, 0, 2'(m), 2'(m));
            drain();
            chk("impulse_count", got.size(), 8);
            if (got.size() > 0) chk("impulse_first", got[0], imp_exp[m]);
        end

        // Ramp in bypass
        clear_frame_stats();
        send_frame(2, 0, 2'd3, 2'd3);
        drain();
        chk("ramp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) if (i < got.size()) chk("ramp_value", got[i], ramp_exp[i]);

        // Random backpressure, random images, back-to-back frames incl. mid-frame mode change
        clear_frame_stats();
        rnd_ready = 1'b1;
        send_frame(3, 0, 2'd0, 2'd0);
        send_frame(3, 0, 2'd1, 2'd1);
        send_frame(3, 0, 2'd2, 2'd2);
        send_frame(3, 0, 2'd0, 2'd3);
        send_frame(3, 0, 2'd3, 2'd3);
        drain();
        rnd_ready = 1'b0;
        repeat (2) cycle();
        chk("random_count", got.size(), 40);
        chk("random_fd_count", fd_cnt, 5);

        // Reset after pixel (4,5) discards in-flight work
        for (int i = 0; i < 4 * W + 6; i++) send_px(8'd200, 2'd0);
        bus.din_valid = 1'b0;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("midreset_dout_valid", 32'(bus.dout_valid), 32'd0);
        sb_val.delete();
        sb_fd.delete();
        t_row = 0;
        t_col = 0;
        cycle();
        chk("midreset_dout_valid_2", 32'(bus.dout_valid), 32'd0);
        clear_frame_stats();
        send_frame(0, 50, 2'd0, 2'd0);
        drain();
        chk("post_reset_count", got.size(), 8);
        chk("post_reset_fd_count", fd_cnt, 1);
        for (int i = 0; i < got.size(); i++) chk("post_reset_value", got[i], 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
